// File: rtl/dca_matrix_register_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : dca_matrix_register_sequencer_pkg
// Brief  : Op codes, FSM encoding and matrix dimension helpers for the sequencer.
// Rev    : 1.0
// ============================================================================
package dca_matrix_register_sequencer_pkg;

  typedef enum logic [1:0] {
    DCA_MSEQ_OP_LOAD           = 2'd0,
    DCA_MSEQ_OP_DRAIN          = 2'd1,
    DCA_MSEQ_OP_LOAD_TRANSPOSE = 2'd2,
    DCA_MSEQ_OP_SWAP           = 2'd3
  } dca_mseq_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_XPOSE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_SWAP  = 3'd5,
    ST_DONE  = 3'd6
  } dca_mseq_state_e;

  localparam int DCA_MSEQ_MIN_DIM = 2;

  // The register is square; the selector maps directly to the side length.
  function automatic int dca_matrix_num_row(input int size_para);
    return (size_para < DCA_MSEQ_MIN_DIM) ? DCA_MSEQ_MIN_DIM : size_para;
  endfunction

  function automatic int dca_matrix_num_col(input int size_para);
    return dca_matrix_num_row(size_para);
  endfunction

  function automatic int dca_tensor_row_bw(input int size_para, input int bw_scalar);
    return dca_matrix_num_col(size_para) * bw_scalar;
  endfunction

  function automatic int dca_row_cnt_bw(input int num_row);
    return $clog2(num_row);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dca_matrix_register_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : dca_matrix_register_sequencer_if
// Brief  : Command, row-stream and matrix-register move bundle for the sequencer.
// Rev    : 1.0
// ============================================================================
interface dca_matrix_register_sequencer_if #(
  parameter int BW_TENSOR_ROW = 256,
  parameter int ROW_CNT_W     = 3
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic                     cmd_clear;
  logic                     abort;
  logic                     in_valid;
  logic                     in_ready;
  logic [BW_TENSOR_ROW-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [BW_TENSOR_ROW-1:0] out_data;
  logic                     mreg_init;
  logic                     mreg_move_wenable;
  logic [BW_TENSOR_ROW-1:0] mreg_move_wdata_list;
  logic                     mreg_move_renable;
  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list;
  logic                     mreg_transpose;
  logic                     busy;
  logic                     done;
  logic [ROW_CNT_W-1:0]     row_count;

  // Front-end (DMA / stream) side.
  modport master (
    output cmd_valid, cmd_op, cmd_clear, abort, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, busy, done, row_count
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_clear, abort, in_valid, in_data, out_ready,
           mreg_move_rdata_list,
    output cmd_ready, in_ready, out_valid, out_data, busy, done, row_count,
           mreg_init, mreg_move_wenable, mreg_move_wdata_list, mreg_move_renable,
           mreg_transpose
  );

  // Matrix register side.
  modport mreg (
    input  mreg_init, mreg_move_wenable, mreg_move_wdata_list, mreg_move_renable,
           mreg_transpose,
    output mreg_move_rdata_list
  );
endinterface
`default_nettype wire

// File: rtl/dca_matrix_register_sequencer_row_counter.sv
`default_nettype none
// ============================================================================
// Module : dca_row_counter
// Brief  : Row counter that wraps at NUM_ROW, with clear and last-row flag.
// Rev    : 1.0
// ============================================================================
module dca_row_counter #(
  parameter int NUM_ROW = 8,
  parameter int CNT_W   = $clog2(NUM_ROW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign last  = (count_q == CNT_W'(NUM_ROW - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/dca_matrix_register_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dca_matrix_register_sequencer
// Brief  : Turns LOAD/DRAIN/LOAD_TRANSPOSE/SWAP commands into matrix move pulses.
// Rev    : 1.0
// ============================================================================
module dca_matrix_register_sequencer
  import dca_matrix_register_sequencer_pkg::*;
#(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int BW_TENSOR_SCALAR = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  dca_matrix_register_sequencer_if.slave bus
);
  localparam int MATRIX_NUM_ROW = dca_matrix_num_row(MATRIX_SIZE_PARA);
  localparam int BW_TENSOR_ROW  = dca_tensor_row_bw(MATRIX_SIZE_PARA, BW_TENSOR_SCALAR);
  localparam int ROW_CNT_W      = dca_row_cnt_bw(MATRIX_NUM_ROW);

  dca_mseq_state_e state_q;
  dca_mseq_state_e state_d;
  dca_mseq_op_e    op_q;
  dca_mseq_op_e    op_d;

  logic                     kill;
  logic                     beat;
  logic                     cnt_clear;
  logic                     row_last;
  logic [ROW_CNT_W-1:0]     row_count;
  logic                     in_ready;
  logic                     out_valid;
  logic                     mreg_init;
  logic                     mreg_wen;
  logic                     mreg_ren;
  logic                     mreg_xpose;
  logic                     done;
  logic [BW_TENSOR_ROW-1:0] row_wdata;
  logic [BW_TENSOR_ROW-1:0] row_rdata;

  // Reset mid-operation behaves like abort for the current cycle's outputs.
  assign kill = rst | bus.abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= DCA_MSEQ_OP_LOAD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mreg_init  = 1'b0;
    mreg_wen   = 1'b0;
    mreg_ren   = 1'b0;
    mreg_xpose = 1'b0;
    done       = 1'b0;
    beat       = 1'b0;
    cnt_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d = dca_mseq_op_e'(bus.cmd_op);
          case (dca_mseq_op_e'(bus.cmd_op))
            DCA_MSEQ_OP_LOAD,
            DCA_MSEQ_OP_LOAD_TRANSPOSE: state_d = bus.cmd_clear ? ST_INIT : ST_LOAD;
            DCA_MSEQ_OP_DRAIN:          state_d = ST_DRAIN;
            default:                    state_d = ST_SWAP;
          endcase
        end
      end

      ST_INIT: begin
        if (!kill) begin
          mreg_init = 1'b1;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (!kill) begin
          in_ready = 1'b1;
          mreg_wen = bus.in_valid;
          beat     = bus.in_valid;
          if (bus.in_valid && row_last) begin
            state_d = (op_q == DCA_MSEQ_OP_LOAD_TRANSPOSE) ? ST_XPOSE : ST_DONE;
          end
        end
      end

      ST_XPOSE: begin
        if (!kill) begin
          mreg_xpose = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_DRAIN: begin
        if (!kill) begin
          out_valid = 1'b1;
          mreg_ren  = bus.out_ready;
          beat      = bus.out_ready;
          if (bus.out_ready && row_last) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SWAP: begin
        // Both streams move in lockstep so each shift retires one old row
        // and admits one new row.
        if (!kill) begin
          in_ready  = bus.out_ready;
          out_valid = bus.in_valid;
          beat      = bus.in_valid & bus.out_ready;
          mreg_wen  = beat;
          mreg_ren  = beat;
          if (beat && row_last) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (!kill) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (kill && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      cnt_clear = 1'b1;
    end
  end

  dca_row_counter #(
    .NUM_ROW (MATRIX_NUM_ROW),
    .CNT_W   (ROW_CNT_W)
  ) u_row_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (beat),
    .count (row_count),
    .last  (row_last)
  );

  assign row_wdata = bus.in_data;
  assign row_rdata = bus.mreg_move_rdata_list;

  assign bus.cmd_ready            = (state_q == ST_IDLE);
  assign bus.busy                 = (state_q != ST_IDLE);
  assign bus.done                 = done;
  assign bus.row_count            = row_count;
  assign bus.in_ready             = in_ready;
  assign bus.out_valid            = out_valid;
  assign bus.out_data             = row_rdata;
  assign bus.mreg_init            = mreg_init;
  assign bus.mreg_move_wenable    = mreg_wen;
  assign bus.mreg_move_wdata_list = row_wdata;
  assign bus.mreg_move_renable    = mreg_ren;
  assign bus.mreg_transpose       = mreg_xpose;
endmodule
`default_nettype wire
